// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and opcode classification
// for the sequential ALU and its combinational core.
package alu_pkg;

   localparam logic [3:0] OP_ADD_C  = 4'b0000;
   localparam logic [3:0] OP_ADD    = 4'b0001;
   localparam logic [3:0] OP_SUB    = 4'b0010;
   localparam logic [3:0] OP_DEC_C  = 4'b0011;
   localparam logic [3:0] OP_AND    = 4'b0100;
   localparam logic [3:0] OP_OR     = 4'b0101;
   localparam logic [3:0] OP_XOR    = 4'b0110;
   localparam logic [3:0] OP_NOT    = 4'b0111;
   localparam logic [3:0] OP_SHR    = 4'b1000;
   localparam logic [3:0] OP_SHL    = 4'b1001;
   localparam logic [3:0] OP_ROR    = 4'b1010;
   localparam logic [3:0] OP_ROL    = 4'b1011;
   localparam logic [3:0] OP_ASR    = 4'b1100;
   localparam logic [3:0] OP_SHL0   = 4'b1101;
   localparam logic [3:0] OP_PASS_A = 4'b1110;
   localparam logic [3:0] OP_PASS_B = 4'b1111;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      SHIFT,
      DONE
   } state_t;

   // Shift/rotate opcodes iterate one position per cycle; pass A/B share
   // the sel[3]=1 half of the map but complete in a single EXEC cycle.
   function automatic logic is_shift_op(input logic [3:0] sel);
      return sel[3] && (sel[3:1] != 3'b111);
   endfunction

endpackage

// File: rtl/alu_core_n.sv
// Combinational WIDTH-bit datapath: add/subtract family, bitwise logic,
// single-position shift/rotate and operand pass-through.
module alu_core_n
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [3:0]       sel,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   logic [WIDTH-1:0] addend;
   logic [WIDTH:0]   sum;
   logic             arith_ovf;

   // All four arithmetic ops are A + addend + cin with a different addend.
   always_comb begin
      addend = '0;
      case (sel[1:0])
         2'b00:   addend = '0;
         2'b01:   addend = b;
         2'b10:   addend = ~b;
         default: addend = '1;
      endcase
   end

   assign sum       = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};
   assign arith_ovf = (a[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

   always_comb begin
      result = '0;
      cout   = 1'b0;
      ovf    = 1'b0;
      case (sel)
         OP_ADD_C, OP_ADD, OP_SUB, OP_DEC_C: begin
            result = sum[WIDTH-1:0];
            cout   = sum[WIDTH];
            ovf    = arith_ovf;
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOT:  result = ~a;
         OP_SHR: begin
            result = {cin, a[WIDTH-1:1]};
            cout   = a[0];
         end
         OP_SHL: begin
            result = {a[WIDTH-2:0], cin};
            cout   = a[WIDTH-1];
         end
         OP_ROR: begin
            result = {a[0], a[WIDTH-1:1]};
            cout   = a[0];
         end
         OP_ROL: begin
            result = {a[WIDTH-2:0], a[WIDTH-1]};
            cout   = a[WIDTH-1];
         end
         OP_ASR: begin
            result = {a[WIDTH-1], a[WIDTH-1:1]};
            cout   = a[0];
         end
         OP_SHL0: begin
            result = {a[WIDTH-2:0], 1'b0};
            cout   = a[WIDTH-1];
         end
         OP_PASS_A: result = a;
         default:   result = b;
      endcase
   end

endmodule

// File: rtl/alu_seq_n.sv
// Sequential ALU: captures a request, runs it through the core once (or once
// per shift position), then publishes result and flags with a done pulse.
module alu_seq_n
   import alu_pkg::*;
#(
   parameter  int WIDTH   = 8,
   localparam int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               cin,
   input  logic [3:0]         sel,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [WIDTH-1:0]   result,
   output logic               cout,
   output logic               ovf,
   output logic               zero,
   output logic               busy,
   output logic               done
);

   state_t             state;
   logic [WIDTH-1:0]   work;
   logic [WIDTH-1:0]   op_b;
   logic               op_cin;
   logic [3:0]         op_sel;
   logic [SHAMT_W-1:0] count;
   logic               pend_cout;
   logic               pend_ovf;

   logic [WIDTH-1:0]   core_result;
   logic               core_cout;
   logic               core_ovf;

   // The working register doubles as operand A, so one core serves both the
   // single-cycle ops and every step of a multi-cycle shift.
   alu_core_n #(
      .WIDTH(WIDTH)
   ) u_core (
      .a      (work),
      .b      (op_b),
      .cin    (op_cin),
      .sel    (op_sel),
      .result (core_result),
      .cout   (core_cout),
      .ovf    (core_ovf)
   );

   // busy stays high through the done cycle, which is spent in IDLE, so a
   // start seen there is rejected by the busy check rather than by state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         work      <= '0;
         op_b      <= '0;
         op_cin    <= 1'b0;
         op_sel    <= '0;
         count     <= '0;
         pend_cout <= 1'b0;
         pend_ovf  <= 1'b0;
         result    <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (busy) begin
                  busy <= 1'b0;
               end else if (start) begin
                  work      <= a;
                  op_b      <= b;
                  op_cin    <= cin;
                  op_sel    <= sel;
                  count     <= shamt;
                  pend_cout <= 1'b0;
                  pend_ovf  <= 1'b0;
                  busy      <= 1'b1;
                  state     <= is_shift_op(sel) ? SHIFT : EXEC;
               end
            end
            EXEC: begin
               work      <= core_result;
               pend_cout <= core_cout;
               pend_ovf  <= core_ovf;
               state     <= DONE;
            end
            SHIFT: begin
               // A zero distance still spends one cycle here and leaves A untouched.
               if (count == '0) begin
                  pend_cout <= 1'b0;
                  state     <= DONE;
               end else begin
                  work      <= core_result;
                  pend_cout <= core_cout;
                  count     <= count - SHAMT_W'(1);
                  if (count == SHAMT_W'(1)) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               result <= work;
               cout   <= pend_cout;
               ovf    <= pend_ovf;
               zero   <= (work == '0);
               done   <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_n.sv
// Directed self-checking bench for alu_seq_n at WIDTH=8 with hand-computed
// results, flags, latencies and reset/abort behaviour.
module tb_alu_seq_n;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic [3:0] sel;
   logic [2:0] shamt;
   logic [7:0] result;
   logic       cout;
   logic       ovf;
   logic       zero;
   logic       busy;
   logic       done;

   int assertCount = 0;
   int failCount   = 0;
   int sinceAccept = 0;
   int busyPreDone = 0;

   always #5 clk = ~clk;

   alu_seq_n #(
      .WIDTH(8)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .cin    (cin),
      .sel    (sel),
      .shamt  (shamt),
      .result (result),
      .cout   (cout),
      .ovf    (ovf),
      .zero   (zero),
      .busy   (busy),
      .done   (done)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      sinceAccept++;
      if (busy && !done) busyPreDone++;
   endtask

   // Waits for an idle DUT, presents one request and returns #1 after the accept edge.
   task automatic applyStimulus(input logic [7:0] a_i, input logic [7:0] b_i, input logic cin_i,
                                input logic [3:0] sel_i, input logic [2:0] shamt_i);
      int guard = 0;
      @(negedge clk);
      while (busy && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("accept.busy_idle", busy, 1'b0);
      a     = a_i;
      b     = b_i;
      cin   = cin_i;
      sel   = sel_i;
      shamt = shamt_i;
      start = 1'b1;
      @(posedge clk);
      #1;
      start       = 1'b0;
      sinceAccept = 0;
      busyPreDone = (busy && !done) ? 1 : 0;
   endtask

   task automatic waitDone(input string tag);
      int guard = 0;
      while (!done && guard < 40) begin
         tick();
         guard++;
      end
      checkOutput($sformatf("%s.done_seen", tag), done, 1'b1);
   endtask

   task automatic checkAfterDone(input string tag, input bit pokeStart);
      if (pokeStart) begin
         a     = 8'h33;
         b     = 8'h11;
         sel   = 4'b0001;
         start = 1'b1;
      end
      tick();
      start = 1'b0;
      checkOutput($sformatf("%s.done_pulse", tag), done, 1'b0);
      checkOutput($sformatf("%s.busy_drop", tag), busy, 1'b0);
      if (pokeStart) begin
         tick();
         checkOutput($sformatf("%s.start_in_done_ignored", tag), busy, 1'b0);
      end
   endtask

   task automatic runOp(input string tag, input logic [7:0] a_i, input logic [7:0] b_i,
                        input logic cin_i, input logic [3:0] sel_i, input logic [2:0] shamt_i,
                        input logic [7:0] expRes, input logic expCout, input logic expOvf,
                        input int expLat);
      applyStimulus(a_i, b_i, cin_i, sel_i, shamt_i);
      waitDone(tag);
      checkOutput($sformatf("%s.result", tag), result, expRes);
      checkOutput($sformatf("%s.cout", tag), cout, expCout);
      checkOutput($sformatf("%s.ovf", tag), ovf, expOvf);
      checkOutput($sformatf("%s.zero", tag), zero, (expRes == 8'h00));
      checkOutput($sformatf("%s.latency", tag), sinceAccept, expLat);
      checkAfterDone(tag, 1'b0);
   endtask

   initial begin
      int doneSeen;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      sel   = '0;
      shamt = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      checkOutput("reset.result", result, 8'h00);
      checkOutput("reset.cout", cout, 1'b0);
      checkOutput("reset.ovf", ovf, 1'b0);
      checkOutput("reset.zero", zero, 1'b1);
      checkOutput("reset.busy", busy, 1'b0);
      checkOutput("reset.done", done, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Arithmetic: first one is accepted on the first edge after reset release.
      runOp("add_ovf",   8'h7F, 8'h01, 1'b0, 4'b0001, 3'd0, 8'h80, 1'b0, 1'b1, 2);
      runOp("add_carry", 8'hFF, 8'h01, 1'b0, 4'b0001, 3'd0, 8'h00, 1'b1, 1'b0, 2);
      runOp("sub",       8'h05, 8'h07, 1'b1, 4'b0010, 3'd0, 8'hFE, 1'b0, 1'b0, 2);
      runOp("dec",       8'h80, 8'h00, 1'b0, 4'b0011, 3'd0, 8'h7F, 1'b1, 1'b1, 2);
      runOp("inc_cin",   8'h7F, 8'h00, 1'b1, 4'b0000, 3'd0, 8'h80, 1'b0, 1'b1, 2);

      // Logic ops never report carry or overflow.
      runOp("and", 8'hF0, 8'h3C, 1'b1, 4'b0100, 3'd0, 8'h30, 1'b0, 1'b0, 2);
      runOp("or",  8'h0F, 8'h30, 1'b0, 4'b0101, 3'd0, 8'h3F, 1'b0, 1'b0, 2);
      runOp("xor", 8'hAA, 8'hFF, 1'b0, 4'b0110, 3'd0, 8'h55, 1'b0, 1'b0, 2);
      runOp("not", 8'hFF, 8'h00, 1'b0, 4'b0111, 3'd0, 8'h00, 1'b0, 1'b0, 2);

      // Rotate right by 3 with busy-cycle count ahead of done.
      runOp("ror3", 8'h81, 8'h00, 1'b0, 4'b1010, 3'd3, 8'h30, 1'b0, 1'b0, 4);
      checkOutput("ror3.busy_cycles_before_done", busyPreDone, 4);

      runOp("asr2",    8'h90, 8'h00, 1'b0, 4'b1100, 3'd2, 8'hE4, 1'b0, 1'b0, 3);
      runOp("shl_z",   8'hE4, 8'h00, 1'b1, 4'b1001, 3'd0, 8'hE4, 1'b0, 1'b0, 2);
      runOp("shr_cin", 8'h01, 8'h00, 1'b1, 4'b1000, 3'd1, 8'h80, 1'b1, 1'b0, 2);
      runOp("rol7",    8'h81, 8'h00, 1'b0, 4'b1011, 3'd7, 8'hC0, 1'b0, 1'b0, 8);
      runOp("shl0_4",  8'hFF, 8'h00, 1'b1, 4'b1101, 3'd4, 8'hF0, 1'b1, 1'b0, 5);
      runOp("pass_a",  8'h5A, 8'h00, 1'b0, 4'b1110, 3'd5, 8'h5A, 1'b0, 1'b0, 2);
      runOp("pass_b",  8'h12, 8'h00, 1'b0, 4'b1111, 3'd0, 8'h00, 1'b0, 1'b0, 2);
      runOp("shr_zero", 8'h00, 8'h00, 1'b0, 4'b1000, 3'd3, 8'h00, 1'b0, 1'b0, 4);

      // New request and changed inputs while shifting must not disturb the run.
      applyStimulus(8'h81, 8'h00, 1'b0, 4'b1010, 3'd3);
      a     = 8'h00;
      b     = 8'h55;
      cin   = 1'b1;
      sel   = 4'b0101;
      shamt = 3'd0;
      start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      waitDone("ror_interfere");
      checkOutput("ror_interfere.result", result, 8'h30);
      checkOutput("ror_interfere.cout", cout, 1'b0);
      checkOutput("ror_interfere.latency", sinceAccept, 4);
      checkAfterDone("ror_interfere", 1'b1);

      // Leave result/cout non-reset so the mid-shift reset is observable.
      runOp("shl_cin", 8'hC0, 8'h00, 1'b1, 4'b1001, 3'd2, 8'h03, 1'b1, 1'b0, 3);

      applyStimulus(8'h81, 8'h00, 1'b0, 4'b1011, 3'd7);
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_abort.result", result, 8'h00);
      checkOutput("rst_abort.cout", cout, 1'b0);
      checkOutput("rst_abort.ovf", ovf, 1'b0);
      checkOutput("rst_abort.zero", zero, 1'b1);
      checkOutput("rst_abort.busy", busy, 1'b0);
      checkOutput("rst_abort.done", done, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      doneSeen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done || busy) doneSeen = 1;
      end
      checkOutput("rst_abort.no_done_or_busy", doneSeen, 0);
      runOp("after_reset", 8'h7F, 8'h01, 1'b0, 4'b0001, 3'd0, 8'h80, 1'b0, 1'b1, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish, observed running, expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/alu_seq_n.md
ALU_SEQ_N -- requirements
Module: alu_seq_n

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHAMT_W = clog2(WIDTH).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; accepted only when busy=0.
REQ-005 a  input  WIDTH  operand A, captured on accept.
REQ-006 b  input  WIDTH  operand B, captured on accept.
REQ-007 cin  input  1  carry-in / serial fill bit, captured on accept.
REQ-008 sel  input  4  operation select {s3,s2,s1,s0}, captured on accept.
REQ-009 shamt  input  SHAMT_W  shift distance, captured on accept.
REQ-010 result  output  WIDTH  registered result, held until next completion.
REQ-011 cout  output  1  carry-out / last bit shifted out.
REQ-012 ovf  output  1  signed overflow, arithmetic ops only, else 0.
REQ-013 zero  output  1  result == 0, updated with result.
REQ-014 busy  output  1  high from cycle after accept until done cycle inclusive.
REQ-015 done  output  1  one-cycle pulse when result/flags are updated.

Function
REQ-016 sel=00xx arithmetic: 0000 A+cin, 0001 A+B+cin, 0010 A+~B+cin, 0011 A-1+cin; cout = bit WIDTH of sum; ovf = signed overflow.
REQ-017 sel=01xx logic: 0100 A&B, 0101 A|B, 0110 A^B, 0111 ~A; cout=0, ovf=0.
REQ-018 sel=10xx shift: 1000 SHR fill cin, 1001 SHL fill cin, 1010 ROR, 1011 ROL; ovf=0.
REQ-019 sel=11xx: 1100 ASR (sign fill), 1101 SHL fill 0, 1110 pass A, 1111 pass B; ovf=0.
REQ-020 FSM states IDLE, EXEC, SHIFT, DONE; reset state IDLE.
REQ-021 IDLE: start=1 -> capture inputs; go EXEC for sel[3]=0 or 1110/1111, SHIFT otherwise.
REQ-022 EXEC: one cycle, compute via core, go DONE.
REQ-023 SHIFT: move working register one position per cycle, decrement count; go DONE when count reaches 0; shamt=0 goes DONE after one cycle with result=A, cout=0.
REQ-024 DONE: register result/flags, pulse done for one cycle, return to IDLE; busy drops the following cycle.
REQ-025 Latency: accept at edge k; non-shift done visible after edge k+2; shift done after edge k+1+max(shamt,1).
REQ-026 Shift cout = last bit shifted/rotated out; rotates lose no bits.
REQ-027 start while busy=1 ignored, no queuing; start in the DONE cycle ignored.
REQ-028 Back-to-back: start may be accepted in the cycle busy=0 immediately after done.
REQ-029 Input changes after accept have no effect on the running operation.

Reset
REQ-030 rst_n=0 forces IDLE, result=0, cout=0, ovf=0, zero=1, busy=0, done=0 immediately, asynchronously.
REQ-031 Reset mid-operation aborts it; no done pulse issued for the aborted operation.
REQ-032 First start accepted on the first rising edge with rst_n=1.

Structure
REQ-033 Shared package alu_pkg holds sel opcode constants and FSM state enum.
REQ-034 One sub-module alu_core_n: combinational WIDTH-bit arithmetic/logic/single-step shift, parameter WIDTH.
REQ-035 FSM, count, working register and output registers live in alu_seq_n.

Verification (WIDTH=8)
REQ-036 a=0x7F,b=0x01,cin=0,sel=0001 -> result=0x80,cout=0,ovf=1,zero=0, done after edge k+2.
REQ-037 a=0xFF,b=0x01,cin=0,sel=0001 -> result=0x00,cout=1,zero=1,ovf=0.
REQ-038 a=0x81,sel=1010,shamt=3 -> result=0x30,cout=0 (last bit out), done after edge k+4, busy high 4 cycles.
REQ-039 a=0x90,sel=1100,shamt=2 -> result=0xE4; then shamt=0,sel=1001 -> result=a,done after edge k+2.
REQ-040 start re-asserted with new operands during SHIFT -> ignored, original result returned.
REQ-041 rst_n low during SHIFT -> outputs at reset values, no done pulse; next start completes normally.
